// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one streaming FFT core between two
// sample sources; output frames are tagged with their source channel and last sample.
module fft_frame_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int OUTPUT_WIDTH = 24,
    parameter int FFT_N        = 256,
    parameter int TAG_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s0_valid,
    output logic                      s0_ready,
    input  logic [2*DATA_WIDTH-1:0]   s0_data,
    input  logic                      s1_valid,
    output logic                      s1_ready,
    input  logic [2*DATA_WIDTH-1:0]   s1_data,
    output logic                      core_in_valid,
    input  logic                      core_in_ready,
    output logic [2*DATA_WIDTH-1:0]   core_in_data,
    input  logic                      core_out_valid,
    output logic                      core_out_ready,
    input  logic [2*OUTPUT_WIDTH-1:0] core_out_data,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [2*OUTPUT_WIDTH-1:0] m_axis_data,
    output logic                      m_axis_chan,
    output logic                      m_axis_last,
    output logic                      err,
    output logic                      arb_state
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are
    // both high; ready never depends combinationally on valid of the same side.

    localparam int CW = $clog2(FFT_N);
    localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(FFT_N - 1);
    localparam logic [TW:0]   TAG_FULL  = (TW + 1)'(TAG_DEPTH);
    localparam logic [TW-1:0] PTR_LAST  = TW'(TAG_DEPTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t          state, state_next;
    logic            grant, grant_next;
    logic            rr_ptr, rr_next;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    logic            in_fire, out_fire, push, pop;

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [TW-1:0]        wr_ptr, rd_ptr;
    logic [TW:0]          tag_count;
    logic                 tag_full, tag_empty;

    assign arb_state = (state == ST_STREAM);

    // Input arbitration and per-frame pass-through of the granted channel
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_next       = rr_ptr;
        push          = 1'b0;
        s0_ready      = 1'b0;
        s1_ready      = 1'b0;
        core_in_valid = 1'b0;
        core_in_data  = grant ? s1_data : s0_data;
        case (state)
            ST_IDLE: begin
                if (!tag_full && (s0_valid || s1_valid)) begin
                    grant_next = (s0_valid && s1_valid) ? rr_ptr : s1_valid;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                core_in_valid = grant ? s1_valid : s0_valid;
                s0_ready      = ~grant & core_in_ready;
                s1_ready      = grant & core_in_ready;
                if (core_in_valid && core_in_ready && (in_cnt == CNT_LAST)) begin
                    push       = 1'b1;
                    rr_next    = ~grant;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        in_fire = core_in_valid & core_in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= 1'b0;
            rr_ptr <= 1'b0;
            in_cnt <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_next;
            if (state == ST_IDLE) begin
                in_cnt <= '0;
            end else if (in_fire) begin
                in_cnt <= in_cnt + CW'(1);
            end
        end
    end

    // Output side is gated entirely by the presence of a pending channel tag
    assign tag_empty      = (tag_count == '0);
    assign tag_full       = (tag_count == TAG_FULL);
    assign m_axis_valid   = core_out_valid & ~tag_empty;
    assign core_out_ready = m_axis_ready & ~tag_empty;
    assign m_axis_data    = core_out_data;
    assign m_axis_chan    = tag_mem[rd_ptr];
    assign m_axis_last    = (out_cnt == CNT_LAST);
    assign out_fire       = m_axis_valid & m_axis_ready;
    assign pop            = out_fire & m_axis_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (out_fire) begin
                out_cnt <= out_cnt + CW'(1);
            end
            if (core_out_valid && tag_empty) begin
                err <= 1'b1;
            end
        end
    end

    // Channel-tag FIFO: one bit per frame currently inside the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + TW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + TW'(1);
            end
            case ({push, pop})
                2'b10:   tag_count <= tag_count + (TW + 1)'(1);
                2'b01:   tag_count <= tag_count - (TW + 1)'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: directed scenarios plus randomized frame mixes,
// with a frame-level round-robin model and a frame-buffering FFT core stand-in.
module tb_fft_frame_arbiter;

    localparam int DW = 16;
    localparam int OW = 24;
    localparam int N  = 256;
    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s0_valid = 1'b0, s1_valid = 1'b0;
    logic              s0_ready, s1_ready;
    logic [2*DW-1:0]   s0_data = '0, s1_data = '0;
    logic              core_in_valid;
    logic              core_in_ready = 1'b0;
    logic [2*DW-1:0]   core_in_data;
    logic              core_out_valid = 1'b0;
    logic              core_out_ready;
    logic [2*OW-1:0]   core_out_data = '0;
    logic              m_axis_valid;
    logic              m_axis_ready = 1'b0;
    logic [2*OW-1:0]   m_axis_data;
    logic              m_axis_chan, m_axis_last, err, arb_state;

    always #5 clk = ~clk;

    fft_frame_arbiter #(
        .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .FFT_N(N), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .m_axis_chan(m_axis_chan), .m_axis_last(m_axis_last), .err(err), .arb_state(arb_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [2*DW-1:0] src0[$], src1[$];
    logic [2*OW-1:0] exp0_q[$], exp1_q[$];
    logic            exp_chan_q[$];
    logic [2*OW-1:0] core_d[$], core_pend[$];
    int              core_due[$];

    int in_pct = 100, m_pct = 100, core_delay = 10;
    bit m_toggle = 0, core_stall = 0, force_cov = 0;
    bit m_ptr = 0;
    int in_fires = 0, first_in = 0, last_in = 0, out_total = 0, out_idx = 0;
    int s1_hi = 0, mirror_bad = 0, blocked_hi = 0;

    function automatic logic [2*OW-1:0] xform(input logic [2*DW-1:0] d);
        return {{(OW-DW){d[2*DW-1]}}, d[2*DW-1:DW], {(OW-DW){d[DW-1]}}, d[DW-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Sources, FFT core stand-in, downstream sink and output scoreboard
    always @(posedge clk) begin
        logic f_s0, f_s1, f_in, f_m, mc, ml, ec;
        logic [2*OW-1:0] md, ed;
        f_s0 = s0_valid && s0_ready;
        f_s1 = s1_valid && s1_ready;
        f_in = core_in_valid && core_in_ready;
        f_m  = m_axis_valid && m_axis_ready;
        md = m_axis_data; mc = m_axis_chan; ml = m_axis_last;
        cyc++;
        if (s1_ready) s1_hi++;
        if (s0_ready || s1_ready || core_in_valid) blocked_hi++;
        if (core_out_valid && (core_out_ready !== m_axis_ready)) mirror_bad++;
        if (f_s0 && src0.size() > 0) void'(src0.pop_front());
        if (f_s1 && src1.size() > 0) void'(src1.pop_front());
        if (f_in) begin
            if (in_fires == 0) first_in = cyc;
            last_in = cyc;
            in_fires++;
            core_pend.push_back(xform(core_in_data));
            if (core_pend.size() == N) begin
                for (int i = 0; i < N; i++) begin
                    core_d.push_back(core_pend[i]);
                    core_due.push_back(cyc + core_delay);
                end
                core_pend.delete();
            end
        end
        if (f_m) begin
            out_total++;
            if (core_d.size() > 0) begin
                void'(core_d.pop_front());
                void'(core_due.pop_front());
            end
            check("out_expected", exp_chan_q.size() > 0, 1);
            if (exp_chan_q.size() > 0) begin
                ec = exp_chan_q[0];
                ed = '0;
                if (!ec && exp0_q.size() > 0) ed = exp0_q.pop_front();
                else if (ec && exp1_q.size() > 0) ed = exp1_q.pop_front();
                check("m_axis_chan", mc, ec);
                check("m_axis_data", md, ed);
                check("m_axis_last", ml, out_idx == N - 1);
                out_idx++;
                if (out_idx == N) begin
                    out_idx = 0;
                    void'(exp_chan_q.pop_front());
                end
            end
        end
        #1;
        s0_valid      = (src0.size() > 0);
        s0_data       = s0_valid ? src0[0] : '0;
        s1_valid      = (src1.size() > 0);
        s1_data       = s1_valid ? src1[0] : '0;
        core_in_ready = ($urandom_range(99) < in_pct);
        m_axis_ready  = m_toggle ? ~m_axis_ready : ($urandom_range(99) < m_pct);
        core_out_valid = force_cov || (!core_stall && core_d.size() > 0 && core_due[0] <= cyc);
        core_out_data  = (core_d.size() > 0) ? core_d[0] : '0;
    end

    // Frame-level round robin: pick preferred when both pending, then prefer the other
    task automatic plan(input int n0, input int n1);
        bit pick;
        while (n0 + n1 > 0) begin
            if (n0 > 0 && n1 > 0) pick = m_ptr;
            else pick = (n1 > 0);
            exp_chan_q.push_back(pick);
            if (pick) n1--; else n0--;
            m_ptr = ~pick;
        end
    endtask

    task automatic load(input bit ch, input int nf);
        logic [2*DW-1:0] d;
        for (int i = 0; i < nf * N; i++) begin
            d = $urandom;
            if (ch) begin src1.push_back(d); exp1_q.push_back(xform(d)); end
            else    begin src0.push_back(d); exp0_q.push_back(xform(d)); end
        end
    endtask

    task automatic start(input int n0, input int n1);
        plan(n0, n1);
        load(0, n0);
        load(1, n1);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        src0.delete(); src1.delete(); exp0_q.delete(); exp1_q.delete();
        exp_chan_q.delete(); core_d.delete(); core_due.delete(); core_pend.delete();
        out_idx = 0; m_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        hold_reset();
        in_fires = 0; out_total = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((exp_chan_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < budget, 1);
        repeat (4) @(negedge clk);
        check({tag, "_idle_valid"}, m_axis_valid, 0);
    endtask

    task automatic wait_fires(input string tag, input int target, input int budget);
        int k = 0;
        while (in_fires < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, in_fires, target);
    endtask

    initial begin
        int n0, n1;
        repeat (3) @(negedge clk);
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        check("rst_core_in_valid", core_in_valid, 0);
        check("rst_m_axis_valid", m_axis_valid, 0);
        check("rst_core_out_ready", core_out_ready, 0);
        check("rst_m_axis_last", m_axis_last, 0);
        check("rst_m_axis_chan", m_axis_chan, 0);
        check("rst_err", err, 0);
        check("rst_arb_state", arb_state, 0);
        rst_n = 1'b1;

        // single ch0 frame through a 10-cycle core
        do_reset();
        s1_hi = 0;
        start(1, 0);
        wait_drain("single_drain", 3000);
        check("single_s1_ready_quiet", s1_hi, 0);
        check("single_out_count", out_total, N);

        // contention: both channels always requesting
        do_reset();
        start(2, 2);
        wait_drain("contend_drain", 5000);
        check("contend_in_count", in_fires, 4 * N);
        check("contend_span", last_in - first_in, 4 * (N + 1) - 2);

        // downstream ready toggling every cycle
        do_reset();
        m_toggle = 1; mirror_bad = 0;
        start(1, 1);
        wait_drain("toggle_drain", 5000);
        check("toggle_mirror", mirror_bad, 0);
        check("toggle_out_count", out_total, 2 * N);
        m_toggle = 0;

        // tag FIFO full with the core output stalled
        do_reset();
        core_stall = 1;
        start(3, 2);
        wait_fires("full_accept4", 4 * N, 3000);
        blocked_hi = 0;
        repeat (40) @(negedge clk);
        check("full_no_ready", blocked_hi, 0);
        check("full_no_5th", in_fires, 4 * N);
        check("full_idle", arb_state, 0);
        core_stall = 0;
        wait_drain("full_drain", 5000);
        check("full_5th_after_pop", in_fires, 5 * N);

        // reset in the middle of a ch1 frame after a ch0 frame moved the preference
        do_reset();
        start(1, 0);
        wait_drain("mid_pre_drain", 3000);
        in_fires = 0;
        start(0, 1);
        wait_fires("mid_100", 100, 1000);
        rst_n = 1'b0;
        #1;
        check("mid_s0_ready", s0_ready, 0);
        check("mid_s1_ready", s1_ready, 0);
        check("mid_core_in_valid", core_in_valid, 0);
        check("mid_m_axis_valid", m_axis_valid, 0);
        check("mid_core_out_ready", core_out_ready, 0);
        check("mid_m_axis_last", m_axis_last, 0);
        check("mid_arb_state", arb_state, 0);
        hold_reset();
        in_fires = 0; out_total = 0;
        start(1, 1);
        wait_drain("mid_post_drain", 5000);
        check("mid_post_out", out_total, 2 * N);

        // core output with no frame in flight
        do_reset();
        @(negedge clk);
        force_cov = 1;
        @(negedge clk);
        check("perr_m_valid", m_axis_valid, 0);
        check("perr_core_out_ready", core_out_ready, 0);
        check("perr_err_before", err, 0);
        @(negedge clk);
        check("perr_err_set", err, 1);
        force_cov = 0;
        repeat (3) @(negedge clk);
        check("perr_err_sticky", err, 1);
        check("perr_m_valid_after", m_axis_valid, 0);
        do_reset();
        check("perr_err_cleared", err, 0);

        // randomized frame mixes, backpressure and core latency
        for (int it = 0; it < 4; it++) begin
            do_reset();
            in_pct = $urandom_range(100, 30);
            m_pct = $urandom_range(100, 30);
            core_delay = $urandom_range(20, 1);
            n0 = $urandom_range(2, 0);
            n1 = $urandom_range(2, 0);
            if (n0 + n1 == 0) n0 = 1;
            start(n0, n1);
            wait_drain("rand_drain", 30000);
            check("rand_out_count", out_total, (n0 + n1) * N);
            check("rand_err", err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Frame-granular two-channel arbiter that shares one FFT streaming core between two requesting sample streams. It sits between the requesters and the FFT core's ready/valid ports. It grants the core one whole frame of FFT_N complex samples at a time, round-robin. It tags every output frame with the channel that supplied it and marks the last output sample of each frame.

## Interface
- DATA_WIDTH, 16, width of each real/imag input component
- OUTPUT_WIDTH, 24, width of each real/imag output component
- FFT_N, 256, samples per frame (power of two, ≥ 4)
- TAG_DEPTH, 4, channel-tag FIFO depth; maximum frames in flight inside the core (power of two)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- s0_valid / s1_valid  in  1  requester sample valid
- s0_ready / s1_ready  out  1  requester sample ready
- s0_data / s1_data  in  2*DATA_WIDTH  signed {real, imag}
- core_in_valid  out  1  to FFT core input
- core_in_ready  in  1  from FFT core input
- core_in_data  out  2*DATA_WIDTH  muxed sample to core
- core_out_valid  in  1  FFT core output valid
- core_out_ready  out  1  to FFT core output
- core_out_data  in  2*OUTPUT_WIDTH  core result {real, imag}
- m_axis_valid  out  1  result valid
- m_axis_ready  in  1  downstream ready
- m_axis_data  out  2*OUTPUT_WIDTH  equals core_out_data
- m_axis_chan  out  1  source channel of current output frame
- m_axis_last  out  1  high on sample FFT_N-1 of each output frame
- err  out  1  sticky: core produced output with no tag pending

## Operation
- Input FSM states: IDLE and STREAM. Registers: grant (1 bit), rr_ptr (1 bit, preferred channel), in_cnt (log2 FFT_N bits).
- IDLE: if tag FIFO not full and any sN_valid is high, register grant and go to STREAM. If both are valid, grant rr_ptr. Otherwise grant the valid one. in_cnt is cleared to 0.
- In IDLE, s0_ready, s1_ready and core_in_valid are 0.
- STREAM: combinational pass-through of the granted channel only.
  - core_in_valid = s[grant]_valid; s[grant]_ready = core_in_ready; core_in_data = s[grant]_data.
  - The non-granted ready is 0.
- Each input handshake (core_in_valid & core_in_ready) increments in_cnt.
- On the handshake with in_cnt == FFT_N-1:
  - push grant into the tag FIFO;
  - set rr_ptr = ~grant;
  - return to IDLE; in_cnt wraps to 0.
- A grant is never revoked mid-frame. A requester dropping valid mid-frame stalls the frame.
- Output side:
  - m_axis_valid = core_out_valid & ~tag_empty.
  - core_out_ready = m_axis_ready & ~tag_empty.
  - m_axis_chan = tag FIFO head. m_axis_data = core_out_data.
- Output handshakes increment out_cnt. m_axis_last = (out_cnt == FFT_N-1).
- On the last handshake, pop the tag and wrap out_cnt to 0.
- If core_out_valid is high while the tag FIFO is empty, err sets and stays set until reset. core_out_ready stays 0 in that case.
- Tag FIFO: TAG_DEPTH entries plus an occupancy count.
  - A simultaneous push and pop leaves the count unchanged and the data ordering correct.
  - A push is never attempted when full, because grant requires not-full and occupancy only decreases until the push.

## Timing
- Reset values:
  - FSM = IDLE, rr_ptr = 0 (ch0 preferred), grant = 0;
  - in_cnt = out_cnt = 0, tag FIFO empty, err = 0;
  - s0_ready = s1_ready = 0, core_in_valid = 0, m_axis_valid = 0, core_out_ready = 0, m_axis_last = 0.
- Datapath latency through the block is 0 cycles in both directions; all data paths are combinational muxes.
- Arbitration costs exactly 1 IDLE cycle per frame. Back-to-back frames with core_in_ready held high take FFT_N+1 cycles each.
- The tag is visible at the FIFO head the cycle after the push edge.
- Reset asserted mid-frame clears all state immediately. Partial frames are discarded and no tag is pushed. The FFT core shares rst_n.
- ready never depends on valid from the same side; there are no combinational loops.

## Test plan
- Single frame: ch0 sends 256 samples, core modelled as a 10-cycle delay. Required: s1_ready stays 0; 256 outputs appear with m_axis_chan = 0; m_axis_last is high only on the 256th output.
- Contention: s0_valid and s1_valid held high for 4 frames. Required: grant order 0,1,0,1; 1 idle cycle between frames; output chan sequence 0,1,0,1.
- Output backpressure: m_axis_ready toggled 1/0 every cycle. Required: core_out_ready mirrors m_axis_ready; no samples lost or duplicated; last still on sample 255.
- Tag FIFO full: core output stalled (core_out_valid = 0) while 4 frames are accepted. Required: no 5th grant, s0_ready = s1_ready = 0. After one frame drains (pop), the next grant occurs.
- Reset mid-frame: rst_n pulsed low after 100 input samples. Required: all outputs return to reset values; the next frame starts at in_cnt = 0 with ch0 preferred.
- Protocol error: core_out_valid forced high with an empty tag FIFO. Required: err = 1 from the next cycle and stays 1; m_axis_valid = 0; core_out_ready = 0.
